// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register index range on read port A and streams each word out
// IDLE -> READ (RA held one full cycle) -> SEND (hold until OutReady), with an XOR checksum over captured words.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [ADDR_WIDTH-1:0] FirstReg,
  input  logic [ADDR_WIDTH-1:0] LastReg,
  output logic [ADDR_WIDTH-1:0] RA,
  input  logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic [ADDR_WIDTH-1:0] OutIdx,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [DATA_WIDTH-1:0] Checksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] IdxOne = 1;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   ra_q;
  logic [ADDR_WIDTH-1:0]   last_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [ADDR_WIDTH-1:0]   out_idx_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic [DATA_WIDTH-1:0]   checksum_q;
  logic [ADDR_WIDTH-1:0]   ra_inc_d;

  // RA doubles as the walk index, so the increment is taken from it directly.
  assign ra_inc_d = ra_q + IdxOne;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      ra_q        <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      checksum_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start && !Abort) begin
            if (FirstReg > LastReg) begin
              error_q <= 1'b1;
            end else begin
              last_q     <= LastReg;
              ra_q       <= FirstReg;
              checksum_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (Abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            out_data_q  <= BusA;
            out_idx_q   <= ra_q;
            checksum_q  <= checksum_q ^ BusA;
            out_valid_q <= 1'b1;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (Abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (OutReady) begin
            out_valid_q <= 1'b0;
            // Compare against the latched last index so LastReg=max never wraps.
            if (ra_q == last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              ra_q    <= ra_inc_d;
              state_q <= ST_READ;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign RA       = ra_q;
  assign OutData  = out_data_q;
  assign OutIdx   = out_idx_q;
  assign OutValid = out_valid_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;
  assign Checksum = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - randomized bench for regfile_dump_reader against a register-array model
// The model holds the register file contents; expectations come from walking that array.
module tb_regfile_dump_reader;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Abort;
  logic [4:0]  FirstReg;
  logic [4:0]  LastReg;
  logic [4:0]  RA;
  logic [31:0] BusA;
  logic [31:0] OutData;
  logic [4:0]  OutIdx;
  logic        OutValid;
  logic        OutReady;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [31:0] Checksum;

  logic [31:0] rf [32];
  int vectors;
  int miscompares;

  regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
    .FirstReg(FirstReg), .LastReg(LastReg), .RA(RA), .BusA(BusA),
    .OutData(OutData), .OutIdx(OutIdx), .OutValid(OutValid), .OutReady(OutReady),
    .Busy(Busy), .Done(Done), .Error(Error), .Checksum(Checksum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] rd(input int i);
    return (i == 0) ? 32'h0 : rf[i];
  endfunction

  assign BusA = rd(int'(RA));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // mode: 0 = OutReady always high, 1 = random OutReady, 2 = OutReady low for 3 valid cycles per word
  task automatic run_dump(input int first, input int last, input int mode, input int abort_idx);
    logic [31:0] exp_ck;
    int exp_idx, hs, cyc, wait_cnt;
    bit finished, hand, aborting;
    exp_ck = 32'h0; exp_idx = first; hs = 0; cyc = 0; wait_cnt = 0; finished = 0;
    Start = 1'b1; FirstReg = 5'(first); LastReg = 5'(last); OutReady = 1'b0; Abort = 1'b0;
    tick();
    Start = 1'b0;
    FirstReg = 5'($urandom); LastReg = 5'($urandom);
    check("busy_after_start", 32'(Busy), 32'd1);
    check("ra_after_start", 32'(RA), 32'(first));
    while (!finished && cyc < 400) begin
      case (mode)
        0: OutReady = 1'b1;
        1: OutReady = ($urandom_range(0, 2) == 0);
        default: OutReady = (wait_cnt >= 3);
      endcase
      Start = 1'($urandom_range(0, 1));
      check("busy_during", 32'(Busy), 32'd1);
      if (OutValid) begin
        check("out_idx", 32'(OutIdx), 32'(exp_idx));
        check("out_data", OutData, rd(exp_idx));
        wait_cnt++;
      end
      aborting = OutValid && (exp_idx == abort_idx);
      if (aborting) begin
        Abort = 1'b1;
        OutReady = 1'b1;
      end
      hand = OutValid && OutReady;
      tick();
      Abort = 1'b0;
      cyc++;
      if (aborting) begin
        exp_ck ^= rd(exp_idx);
        check("abort_valid", 32'(OutValid), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_checksum", Checksum, exp_ck);
        Start = 1'b0;
        for (int k = 0; k < 4; k++) begin
          tick();
          check("abort_no_more", 32'({OutValid, Busy, Done}), 32'd0);
        end
        finished = 1;
      end else if (hand) begin
        hs++;
        wait_cnt = 0;
        exp_ck ^= rd(exp_idx);
        if (exp_idx == last) begin
          Start = 1'b0;
          check("done_pulse", 32'(Done), 32'd1);
          check("done_busy", 32'(Busy), 32'd0);
          check("done_valid", 32'(OutValid), 32'd0);
          check("done_error", 32'(Error), 32'd0);
          check("checksum", Checksum, exp_ck);
          check("handshakes", 32'(hs), 32'(last - first + 1));
          if (mode == 0) check("done_latency", 32'(cyc), 32'(2 * (last - first + 1)));
          tick();
          check("done_one_cycle", 32'(Done), 32'd0);
          check("idle_valid", 32'(OutValid), 32'd0);
          check("checksum_hold", Checksum, exp_ck);
          finished = 1;
        end else begin
          check("no_early_done", 32'(Done), 32'd0);
          exp_idx++;
        end
      end else begin
        check("no_done", 32'(Done), 32'd0);
      end
    end
    Start = 1'b0;
    if (!finished) check("dump_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] ck_before;
    logic [4:0]  ra_before;
    int f, l;
    vectors = 0; miscompares = 0;
    Reset_n = 1'b0; Start = 1'b0; Abort = 1'b0; OutReady = 1'b0;
    FirstReg = 5'd0; LastReg = 5'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    tick(); tick();
    check("rst_ra", 32'(RA), 32'd0);
    check("rst_data", OutData, 32'd0);
    check("rst_idx", 32'(OutIdx), 32'd0);
    check("rst_flags", 32'({OutValid, Busy, Done, Error}), 32'd0);
    check("rst_checksum", Checksum, 32'd0);
    Reset_n = 1'b1;
    tick();

    run_dump(0, 31, 0, -1);
    run_dump(5, 7, 2, -1);

    // Rejected range: Error pulse, nothing else moves.
    ck_before = Checksum; ra_before = RA;
    Start = 1'b1; FirstReg = 5'd9; LastReg = 5'd3;
    tick();
    Start = 1'b0;
    check("bad_error", 32'(Error), 32'd1);
    check("bad_busy", 32'(Busy), 32'd0);
    check("bad_done", 32'(Done), 32'd0);
    check("bad_ra", 32'(RA), 32'(ra_before));
    check("bad_checksum", Checksum, ck_before);
    tick();
    check("bad_error_pulse", 32'(Error), 32'd0);

    rf[31] = 32'hDEAD_BEEF;
    run_dump(31, 31, 0, -1);
    check("single_idx", 32'(OutIdx), 32'd31);
    check("single_checksum", Checksum, 32'hDEAD_BEEF);

    // Abort in IDLE beats Start.
    Start = 1'b1; Abort = 1'b1; FirstReg = 5'd1; LastReg = 5'd2;
    tick();
    Start = 1'b0; Abort = 1'b0;
    check("abort_idle_busy", 32'(Busy), 32'd0);

    run_dump(0, 31, 0, 4);
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    run_dump(0, 31, 1, -1);
    for (int t = 0; t < 6; t++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      run_dump(f, l, 1, ($urandom_range(0, 3) == 0) ? $urandom_range(f, l) : -1);
    end

    // Asynchronous reset in the middle of SEND.
    Start = 1'b1; FirstReg = 5'd3; LastReg = 5'd20; OutReady = 1'b0;
    tick();
    Start = 1'b0;
    tick(); tick();
    check("pre_reset_valid", 32'(OutValid), 32'd1);
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_flags", 32'({OutValid, Busy, Done}), 32'd0);
    check("async_ra", 32'(RA), 32'd0);
    check("async_data", OutData, 32'd0);
    check("async_checksum", Checksum, 32'd0);
    #2;
    Reset_n = 1'b1;
    tick();
    check("post_reset_idle", 32'({OutValid, Busy, Done, Error}), 32'd0);
    run_dump(0, 3, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
